// File: rtl/smaesh_host_bridge_pkg.sv
// Shared definitions for the host-side key/ciphertext bridge of the masked AES core.
package smaesh_host_bridge_pkg;

    localparam logic [1:0] KEY_CFG_128  = 2'd0;
    localparam logic [1:0] KEY_CFG_192  = 2'd1;
    localparam logic [1:0] KEY_CFG_256  = 2'd2;
    localparam logic [1:0] KEY_CFG_RSVD = 2'd3;

    localparam int WORD_W   = 32;
    localparam int KEY_WRDS = 8;
    localparam int CT_WRDS  = 4;
    localparam int BLOCK_W  = 128;

    typedef enum logic {K_IDLE, K_SEND} key_state_t;
    typedef enum logic {C_EMPTY, C_FULL} ct_state_t;

    // Number of 32-bit key words streamed for a given key-size configuration.
    function automatic logic [3:0] key_words(input logic [1:0] cfg);
        logic [3:0] n;
        case (cfg)
            KEY_CFG_128: n = 4'd4;
            KEY_CFG_192: n = 4'd6;
            KEY_CFG_256: n = 4'd8;
            default:     n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/smaesh_host_bridge_recombine.sv
// XOR recombination of d Boolean shares into one unmasked value.
module shares_recombine #(
    parameter int d     = 2,
    parameter int count = 128
) (
    input  logic [count*d-1:0] i_shares,
    output logic [count-1:0]   o_combined
);

    // Fold every share into the running XOR; share j sits at bits [count*j +: count].
    always_comb begin
        o_combined = '0;
        for (int j = 0; j < d; j++) begin
            o_combined = o_combined ^ i_shares[count*j +: count];
        end
    end

endmodule

// File: rtl/smaesh_host_bridge.sv
// Host bridge: serialises a full key into 32-bit words toward the core and
// recombines/serialises the core's shared ciphertext into four 32-bit words.
module smaesh_host_bridge
    import smaesh_host_bridge_pkg::*;
#(
    parameter int d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [255:0]     key_data,
    input  logic [1:0]       key_size_cfg,
    input  logic             key_inverse,
    output logic             core_key_valid,
    input  logic             core_key_ready,
    output logic [31:0]      core_key_data,
    output logic [1:0]       core_key_size_cfg,
    output logic             core_key_inverse,
    output logic             key_err,
    input  logic             ct_valid,
    output logic             ct_ready,
    input  logic [128*d-1:0] ct_shares,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             out_last
);

    key_state_t        r_kstate;
    logic [WORD_W-1:0] r_key_w [KEY_WRDS];
    logic [1:0]        r_cfg;
    logic              r_inv;
    logic [3:0]        r_n;
    logic [2:0]        r_wk;
    logic              r_core_key_valid;
    logic [WORD_W-1:0] r_core_key_data;
    logic              r_key_err;

    ct_state_t         r_cstate;
    logic [WORD_W-1:0] r_ct_w [CT_WRDS];
    logic [1:0]        r_wc;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_word;
    logic              r_out_last;

    logic [BLOCK_W-1:0] w_plain;
    logic [2:0]         w_wk_nxt;
    logic [1:0]         w_wc_nxt;
    logic               w_key_hs;
    logic               w_ct_hs;
    logic               w_key_last;

    shares_recombine #(
        .d     (d),
        .count (BLOCK_W)
    ) u_recombine (
        .i_shares   (ct_shares),
        .o_combined (w_plain)
    );

    // Readies come from state only (never from downstream readies) and are held low during reset.
    assign key_ready = (r_kstate == K_IDLE) && !rst;
    assign ct_ready  = (r_cstate == C_EMPTY) && !rst;

    assign w_key_hs   = key_valid && key_ready;
    assign w_ct_hs    = ct_valid && ct_ready;
    assign w_wk_nxt   = r_wk + 3'd1;
    assign w_wc_nxt   = r_wc + 2'd1;
    assign w_key_last = ({1'b0, r_wk} == (r_n - 4'd1));

    assign core_key_valid    = r_core_key_valid;
    assign core_key_data     = r_core_key_data;
    assign core_key_size_cfg = r_cfg;
    assign core_key_inverse  = r_inv;
    assign key_err           = r_key_err;

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_last  = r_out_last;

    // Key streamer: latch the whole key on accept, then present one word per core handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kstate         <= K_IDLE;
            r_cfg            <= KEY_CFG_128;
            r_inv            <= 1'b0;
            r_n              <= 4'd0;
            r_wk             <= 3'd0;
            r_core_key_valid <= 1'b0;
            r_core_key_data  <= '0;
            r_key_err        <= 1'b0;
            for (int i = 0; i < KEY_WRDS; i++) begin
                r_key_w[i] <= '0;
            end
        end else begin
            r_key_err <= 1'b0;
            case (r_kstate)
                K_IDLE: begin
                    if (w_key_hs) begin
                        for (int i = 0; i < KEY_WRDS; i++) begin
                            r_key_w[i] <= key_data[WORD_W*i +: WORD_W];
                        end
                        r_cfg           <= key_size_cfg;
                        r_inv           <= key_inverse;
                        r_n             <= key_words(key_size_cfg);
                        r_wk            <= 3'd0;
                        r_core_key_data <= key_data[WORD_W-1:0];
                        // A reserved size is accepted but dropped: flag it, emit nothing.
                        if (key_size_cfg == KEY_CFG_RSVD) begin
                            r_key_err <= 1'b1;
                        end else begin
                            r_kstate         <= K_SEND;
                            r_core_key_valid <= 1'b1;
                        end
                    end
                end
                K_SEND: begin
                    if (core_key_ready) begin
                        if (w_key_last) begin
                            r_kstate         <= K_IDLE;
                            r_core_key_valid <= 1'b0;
                        end else begin
                            r_wk            <= w_wk_nxt;
                            r_core_key_data <= r_key_w[w_wk_nxt];
                        end
                    end
                end
            endcase
        end
    end

    // Ciphertext serializer: capture the recombined block, then emit words 0..3 with last on word 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate    <= C_EMPTY;
            r_wc        <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < CT_WRDS; i++) begin
                r_ct_w[i] <= '0;
            end
        end else begin
            case (r_cstate)
                C_EMPTY: begin
                    if (w_ct_hs) begin
                        for (int i = 0; i < CT_WRDS; i++) begin
                            r_ct_w[i] <= w_plain[WORD_W*i +: WORD_W];
                        end
                        r_wc        <= 2'd0;
                        r_out_word  <= w_plain[WORD_W-1:0];
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_cstate    <= C_FULL;
                    end
                end
                C_FULL: begin
                    if (out_ready) begin
                        if (r_wc == 2'd3) begin
                            r_cstate    <= C_EMPTY;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_wc       <= w_wc_nxt;
                            r_out_word <= r_ct_w[w_wc_nxt];
                            r_out_last <= (w_wc_nxt == 2'd3);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smaesh_host_bridge.sv
// Scoreboard bench for smaesh_host_bridge: expected key and ciphertext words are
// queued when upstream stimulus is driven and compared as the DUT emits them.
module tb_smaesh_host_bridge;

    localparam int D = 3;

    logic             clk;
    logic             rst;
    logic             key_valid;
    logic             key_ready;
    logic [255:0]     key_data;
    logic [1:0]       key_size_cfg;
    logic             key_inverse;
    logic             core_key_valid;
    logic             core_key_ready;
    logic [31:0]      core_key_data;
    logic [1:0]       core_key_size_cfg;
    logic             core_key_inverse;
    logic             key_err;
    logic             ct_valid;
    logic             ct_ready;
    logic [128*D-1:0] ct_shares;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic             out_last;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  cfg;
        logic        inv;
    } kexp_t;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } cexp_t;

    kexp_t kq[$];
    cexp_t cq[$];

    int checks   = 0;
    int failures = 0;

    smaesh_host_bridge #(.d(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .key_valid         (key_valid),
        .key_ready         (key_ready),
        .key_data          (key_data),
        .key_size_cfg      (key_size_cfg),
        .key_inverse       (key_inverse),
        .core_key_valid    (core_key_valid),
        .core_key_ready    (core_key_ready),
        .core_key_data     (core_key_data),
        .core_key_size_cfg (core_key_size_cfg),
        .core_key_inverse  (core_key_inverse),
        .key_err           (key_err),
        .ct_valid          (ct_valid),
        .ct_ready          (ct_ready),
        .ct_shares         (ct_shares),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_word          (out_word),
        .out_last          (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer a key upstream, wait (bounded) for acceptance, and queue the words the core should see.
    task automatic drive_key(input logic [255:0] data, input logic [1:0] cfg, input logic inv);
        int  n;
        bit  got;
        n = (cfg == 2'd0) ? 4 : (cfg == 2'd1) ? 6 : (cfg == 2'd2) ? 8 : 0;
        got = 0;
        @(posedge clk); #1;
        key_valid = 1'b1; key_data = data; key_size_cfg = cfg; key_inverse = inv;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (key_ready) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL key_accept_timeout: key_ready=%b required 1", key_ready);
        end
        for (int i = 0; i < n; i++) kq.push_back('{data: data[32*i +: 32], cfg: cfg, inv: inv});
        @(posedge clk); #1;
        key_valid = 1'b0; key_data = ~data; key_size_cfg = 2'd3; key_inverse = ~inv;
    endtask

    // Offer a share set upstream and queue the four plaintext words expected downstream.
    task automatic drive_ct(input logic [128*D-1:0] shares, input logic [127:0] plain);
        bit got;
        got = 0;
        @(posedge clk); #1;
        ct_valid = 1'b1; ct_shares = shares;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ct_ready) begin got = 1; break; end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ct_accept_timeout: ct_ready=%b required 1", ct_ready);
        end
        for (int k = 0; k < 4; k++) cq.push_back('{w: plain[32*k +: 32], last: (k == 3)});
        @(posedge clk); #1;
        ct_valid = 1'b0; ct_shares = ~shares;
    endtask

    function automatic logic [128*D-1:0] make_shares(input logic [127:0] plain);
        logic [127:0] a, b;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        return {a ^ b ^ plain, b, a};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({key_ready, ct_ready, core_key_valid, out_valid, key_err, out_last} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {key_ready, ct_ready, core_key_valid, out_valid, key_err, out_last});
        end
        checks++;
        if ({core_key_data, out_word, core_key_size_cfg, core_key_inverse} !== 67'd0) begin
            failures++;
            $display("FAIL reset_data: got key=%h word=%h cfg=%0d inv=%b required zeros",
                     core_key_data, out_word, core_key_size_cfg, core_key_inverse);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({key_ready, ct_ready} !== 2'b11) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 11", {key_ready, ct_ready});
        end
    endtask

    task automatic test_key128();
        int iters;
        logic [255:0] kd;
        kd = 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100;
        core_key_ready = 1'b1;
        drive_key(kd, 2'd0, 1'b0);
        checks++;
        if (kq.size() != 4 || kq[0].data !== 32'h03020100 || kq[3].data !== 32'h0F0E0D0C) begin
            failures++;
            $display("FAIL key128_expect_build: size=%0d required 4", kq.size());
        end
        iters = 0;
        for (int c = 0; c < 200 && kq.size() > 0; c++) begin
            @(negedge clk);
            iters++;
            checks++;
            if (core_key_valid !== 1'b1 || core_key_data !== kq[0].data ||
                core_key_size_cfg !== kq[0].cfg || core_key_inverse !== kq[0].inv) begin
                failures++;
                $display("FAIL key128_word: got v=%b data=%h cfg=%0d inv=%b required v=1 data=%h cfg=%0d inv=%b",
                         core_key_valid, core_key_data, core_key_size_cfg, core_key_inverse,
                         kq[0].data, kq[0].cfg, kq[0].inv);
            end
            void'(kq.pop_front());
        end
        checks++;
        if (iters != 4) begin
            failures++;
            $display("FAIL key128_burst_len: got %0d cycles required 4", iters);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({key_ready, core_key_valid} !== 2'b10) begin
            failures++;
            $display("FAIL key128_done: got ready,valid=%b required 10", {key_ready, core_key_valid});
        end
    endtask

    task automatic test_key_stall();
        logic [255:0] kd;
        for (int b = 1; b <= 2; b++) begin
            for (int i = 0; i < 8; i++) kd[32*i +: 32] = $urandom;
            core_key_ready = 1'($urandom_range(0, 1));
            drive_key(kd, 2'(b), 1'b1);
            for (int c = 0; c < 300 && kq.size() > 0; c++) begin
                @(negedge clk);
                if (core_key_valid) begin
                    checks++;
                    if (core_key_data !== kq[0].data || core_key_size_cfg !== kq[0].cfg ||
                        core_key_inverse !== kq[0].inv) begin
                        failures++;
                        $display("FAIL key_stall_word: got data=%h cfg=%0d inv=%b required data=%h cfg=%0d inv=%b",
                                 core_key_data, core_key_size_cfg, core_key_inverse,
                                 kq[0].data, kq[0].cfg, kq[0].inv);
                    end
                    if (core_key_ready) void'(kq.pop_front());
                end
                if (kq.size() > 0) begin
                    @(posedge clk); #1;
                    core_key_ready = 1'($urandom_range(0, 1));
                end
            end
            checks++;
            if (kq.size() != 0) begin
                failures++;
                $display("FAIL key_stall_timeout: %0d words left required 0", kq.size());
                kq.delete();
            end
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({key_ready, core_key_valid} !== 2'b10) begin
                failures++;
                $display("FAIL key_stall_done: got ready,valid=%b required 10", {key_ready, core_key_valid});
            end
        end
    endtask

    task automatic test_key_rsvd();
        bit seen_valid;
        core_key_ready = 1'b1;
        drive_key({8{32'hDEADBEEF}}, 2'd3, 1'b0);
        @(negedge clk);
        checks++;
        if ({key_err, core_key_valid, key_ready} !== 3'b101) begin
            failures++;
            $display("FAIL rsvd_err_pulse: got err,valid,ready=%b required 101",
                     {key_err, core_key_valid, key_ready});
        end
        seen_valid = core_key_valid;
        @(negedge clk);
        checks++;
        if (key_err !== 1'b0) begin
            failures++;
            $display("FAIL rsvd_err_width: got key_err=%b required 0", key_err);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (core_key_valid) seen_valid = 1;
        end
        checks++;
        if (seen_valid) begin
            failures++;
            $display("FAIL rsvd_no_words: got core_key_valid=1 required 0");
        end
    endtask

    task automatic test_ct();
        int iters;
        logic [127:0] p, a, b;
        p = 128'h00112233445566778899AABBCCDDEEFF;
        a = 128'h0123456789ABCDEFFEDCBA9876543210;
        b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        drive_ct({a ^ b ^ p, b, a}, p);
        checks++;
        if (cq[0].w !== 32'hCCDDEEFF || cq[3].w !== 32'h00112233) begin
            failures++;
            $display("FAIL ct_expect_build: word0=%h word3=%h", cq[0].w, cq[3].w);
        end
        iters = 0;
        for (int c = 0; c < 200 && cq.size() > 0; c++) begin
            @(negedge clk);
            iters++;
            checks++;
            if (out_valid !== 1'b1 || out_word !== cq[0].w || out_last !== cq[0].last) begin
                failures++;
                $display("FAIL ct_word: got v=%b word=%h last=%b required v=1 word=%h last=%b",
                         out_valid, out_word, out_last, cq[0].w, cq[0].last);
            end
            void'(cq.pop_front());
        end
        checks++;
        if (iters != 4) begin
            failures++;
            $display("FAIL ct_block_len: got %0d cycles required 4", iters);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({ct_ready, out_valid, out_last} !== 3'b100) begin
            failures++;
            $display("FAIL ct_done: got ready,valid,last=%b required 100", {ct_ready, out_valid, out_last});
        end
    endtask

    task automatic test_concurrent();
        fork
            begin
                logic [255:0] kd;
                for (int i = 0; i < 8; i++) kd[32*i +: 32] = $urandom;
                core_key_ready = 1'($urandom_range(0, 1));
                drive_key(kd, 2'd2, 1'($urandom_range(0, 1)));
                for (int c = 0; c < 400 && kq.size() > 0; c++) begin
                    @(negedge clk);
                    if (core_key_valid) begin
                        checks++;
                        if (core_key_data !== kq[0].data || core_key_size_cfg !== kq[0].cfg ||
                            core_key_inverse !== kq[0].inv) begin
                            failures++;
                            $display("FAIL conc_key_word: got data=%h cfg=%0d inv=%b required data=%h cfg=%0d inv=%b",
                                     core_key_data, core_key_size_cfg, core_key_inverse,
                                     kq[0].data, kq[0].cfg, kq[0].inv);
                        end
                        if (core_key_ready) void'(kq.pop_front());
                    end
                    if (kq.size() > 0) begin
                        @(posedge clk); #1;
                        core_key_ready = 1'($urandom_range(0, 1));
                    end
                end
                checks++;
                if (kq.size() != 0) begin
                    failures++;
                    $display("FAIL conc_key_timeout: %0d words left required 0", kq.size());
                    kq.delete();
                end
            end
            begin
                logic [127:0] p;
                for (int blk = 0; blk < 2; blk++) begin
                    p = {$urandom, $urandom, $urandom, $urandom};
                    out_ready = 1'($urandom_range(0, 1));
                    drive_ct(make_shares(p), p);
                    for (int c = 0; c < 400 && cq.size() > 0; c++) begin
                        @(negedge clk);
                        if (out_valid) begin
                            checks++;
                            if (out_word !== cq[0].w || out_last !== cq[0].last) begin
                                failures++;
                                $display("FAIL conc_ct_word: got word=%h last=%b required word=%h last=%b",
                                         out_word, out_last, cq[0].w, cq[0].last);
                            end
                            if (out_ready) void'(cq.pop_front());
                        end
                        if (cq.size() > 0) begin
                            @(posedge clk); #1;
                            out_ready = 1'($urandom_range(0, 1));
                        end
                    end
                    checks++;
                    if (cq.size() != 0) begin
                        failures++;
                        $display("FAIL conc_ct_timeout: %0d words left required 0", cq.size());
                        cq.delete();
                    end
                end
            end
        join
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({key_ready, ct_ready, core_key_valid, out_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL conc_done: got %b required 1100", {key_ready, ct_ready, core_key_valid, out_valid});
        end
    endtask

    task automatic test_rst_mid();
        logic [255:0] kd;
        logic [127:0] p;
        for (int i = 0; i < 8; i++) kd[32*i +: 32] = $urandom;
        p = {$urandom, $urandom, $urandom, $urandom};
        core_key_ready = 1'b1;
        out_ready = 1'b1;
        fork
            drive_key(kd, 2'd0, 1'b1);
            drive_ct(make_shares(p), p);
        join
        repeat (3) @(negedge clk);
        checks++;
        if (core_key_data !== kq[2].data || out_word !== cq[2].w) begin
            failures++;
            $display("FAIL rstmid_word2: got key=%h ct=%h required key=%h ct=%h",
                     core_key_data, out_word, kq[2].data, cq[2].w);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({key_ready, ct_ready} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_ready_low: got %b required 00", {key_ready, ct_ready});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({core_key_valid, out_valid, out_last, key_err, key_ready, ct_ready} !== 6'b000011) begin
            failures++;
            $display("FAIL rstmid_after: got v,v,last,err,kr,cr=%b required 000011",
                     {core_key_valid, out_valid, out_last, key_err, key_ready, ct_ready});
        end
        kq.delete();
        cq.delete();
        for (int i = 0; i < 8; i++) kd[32*i +: 32] = $urandom;
        p = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        fork
            drive_key(kd, 2'd0, 1'b0);
            drive_ct(make_shares(p), p);
        join
        for (int c = 0; c < 100 && kq.size() > 0; c++) begin
            @(negedge clk);
            checks++;
            if (core_key_valid !== 1'b1 || core_key_data !== kq[0].data || core_key_inverse !== kq[0].inv) begin
                failures++;
                $display("FAIL rstmid_fresh_key: got v=%b data=%h inv=%b required v=1 data=%h inv=%b",
                         core_key_valid, core_key_data, core_key_inverse, kq[0].data, kq[0].inv);
            end
            void'(kq.pop_front());
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && cq.size() > 0; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_word !== cq[0].w || out_last !== cq[0].last) begin
                failures++;
                $display("FAIL rstmid_fresh_ct: got v=%b word=%h last=%b required v=1 word=%h last=%b",
                         out_valid, out_word, out_last, cq[0].w, cq[0].last);
            end
            void'(cq.pop_front());
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({key_ready, ct_ready, core_key_valid, out_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL rstmid_fresh_done: got %b required 1100",
                     {key_ready, ct_ready, core_key_valid, out_valid});
        end
    endtask

    initial begin
        rst            = 1'b1;
        key_valid      = 1'b0;
        key_data       = '0;
        key_size_cfg   = 2'd0;
        key_inverse    = 1'b0;
        core_key_ready = 1'b0;
        ct_valid       = 1'b0;
        ct_shares      = '0;
        out_ready      = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_key128();
        test_key_stall();
        test_key_rsvd();
        test_ct();
        test_concurrent();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
